// File: rtl/alu_exec_stage.sv
// alu_exec_stage
//   Multi-cycle execute sequencer wrapped around an external combinational ALU.
//   One decoded operation is accepted per handshake. Its operands are latched
//   and presented to the ALU for one full cycle (EXEC). The ALU result is then
//   captured, with zero/negative/illegal flags, and held until writeback takes it.
//
// Ports
//   clk, reset           rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready  decode -> stage handshake
//   rs1_data, rs2_data   source operands
//   imm, imm_sext        immediate field and its extension mode (1 = sign)
//   use_imm              1 selects the extended immediate as operand B
//   func                 000 add, 001 sub, 010 and, 011 sll, 100 srl, others illegal
//   alu_a/alu_b/alu_op   latched operands and opcode driven to the ALU
//   alu_out              combinational ALU result
//   out_valid/out_ready  stage -> writeback handshake
//   result, zero, neg    captured result and flags
//   illegal              completed op carried an illegal func

module alu_exec_stage #(
  parameter int WIDTH = 32,
  parameter int IMM_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  input  logic [IMM_W-1:0] imm,
  input  logic             imm_sext,
  input  logic             use_imm,
  input  logic [2:0]       func,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             neg,
  output logic             illegal
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       op_q;
  logic             illPend_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             neg_q;
  logic             illegal_q;

  logic [WIDTH-1:0] immExt;
  logic [WIDTH-1:0] bSel;
  logic [WIDTH-1:0] b_d;
  logic [2:0]       op_d;
  logic             shiftOp;
  logic             illFunc;
  logic             accept;

  // Operand B preparation for the operation being accepted this cycle.
  // Shift amounts are masked to 0..31 so the ALU never sees an oversized shift,
  // and illegal funcs are turned into a harmless add whose output is ignored.
  always_comb begin
    immExt  = imm_sext ? {{(WIDTH-IMM_W){imm[IMM_W-1]}}, imm}
                       : {{(WIDTH-IMM_W){1'b0}}, imm};
    bSel    = use_imm ? immExt : rs2_data;
    shiftOp = (func == 3'b011) || (func == 3'b100);
    illFunc = (func > 3'b100);
    b_d     = shiftOp ? {{(WIDTH-5){1'b0}}, bSel[4:0]} : bSel;
    op_d    = illFunc ? 3'b000 : func;
  end

  // in_ready depends combinationally on out_ready so a held result can be
  // retired and replaced on the same edge (back-to-back operation).
  assign in_ready  = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == HOLD);

  assign alu_a   = a_q;
  assign alu_b   = b_q;
  assign alu_op  = op_q;
  assign result  = result_q;
  assign zero    = zero_q;
  assign neg     = neg_q;
  assign illegal = illegal_q;

  // Sequencer: operands latch on accept, the ALU output is captured at the end
  // of EXEC, and HOLD keeps result/flags stable until writeback accepts them.
  // Reset discards any in-flight op and clears the visible result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= 3'b000;
      illPend_q <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b1;
      neg_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) state_q <= EXEC;
        end
        EXEC: begin
          state_q   <= HOLD;
          result_q  <= illPend_q ? '0 : alu_out;
          zero_q    <= illPend_q ? 1'b1 : (alu_out == '0);
          neg_q     <= ~illPend_q & alu_out[WIDTH-1];
          illegal_q <= illPend_q;
        end
        HOLD: begin
          if (out_ready) state_q <= accept ? EXEC : IDLE;
        end
        default: state_q <= IDLE;
      endcase

      if (accept) begin
        a_q       <= rs1_data;
        b_q       <= b_d;
        op_q      <= op_d;
        illPend_q <= illFunc;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Testbench for alu_exec_stage. A small combinational ALU model closes the
// loop on alu_a/alu_b/alu_op. Directed vectors carry hand-computed results;
// expected responses are queued at issue and a monitor process pops and
// compares them whenever writeback takes a result.

module tb_alu_exec_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [15:0] imm;
  logic        imm_sext;
  logic        use_imm;
  logic [2:0]  func;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_op;
  logic [31:0] alu_out;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        neg;
  logic        illegal;

  typedef struct {
    string       name;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [15:0] imm;
    logic        sext;
    logic        useImm;
    logic [2:0]  func;
    logic [31:0] expB;
    logic [2:0]  expOp;
    logic [31:0] expResult;
    logic        expZero;
    logic        expNeg;
    logic        expIll;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] result;
    logic        zero;
    logic        neg;
    logic        ill;
  } resp_t;

  resp_t expQ[$];
  vec_t  vecs[8];
  int    checks = 0;
  int    errors = 0;

  alu_exec_stage #(.WIDTH(32), .IMM_W(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .imm      (imm),
    .imm_sext (imm_sext),
    .use_imm  (use_imm),
    .func     (func),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_op   (alu_op),
    .alu_out  (alu_out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .zero     (zero),
    .neg      (neg),
    .illegal  (illegal)
  );

  // Reference ALU; shifts use the full alu_b so an unmasked amount is visible.
  always_comb begin
    alu_out = 32'h0;
    case (alu_op)
      3'b000: alu_out = alu_a + alu_b;
      3'b001: alu_out = alu_a - alu_b;
      3'b010: alu_out = alu_a & alu_b;
      3'b011: alu_out = alu_a << alu_b;
      3'b100: alu_out = alu_a >> alu_b;
      default: alu_out = 32'hDEADBEEF;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  function automatic vec_t mk(input string name, input logic [31:0] rs1, input logic [31:0] rs2,
                              input logic [15:0] im, input logic sx, input logic ui, input logic [2:0] fn,
                              input logic [31:0] eb, input logic [2:0] eo, input logic [31:0] er,
                              input logic ez, input logic en, input logic ei);
    vec_t v;
    v.name = name; v.rs1 = rs1; v.rs2 = rs2; v.imm = im; v.sext = sx; v.useImm = ui;
    v.func = fn; v.expB = eb; v.expOp = eo; v.expResult = er;
    v.expZero = ez; v.expNeg = en; v.expIll = ei;
    return v;
  endfunction

  // Monitor: every writeback handshake must match the oldest queued response.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_result actual=%h required=none", result);
        end else begin
          resp_t r;
          r = expQ.pop_front();
          checkOutput({r.name, "_result"}, result, r.result);
          checkOutput({r.name, "_zero"}, 32'(zero), 32'(r.zero));
          checkOutput({r.name, "_neg"}, 32'(neg), 32'(r.neg));
          checkOutput({r.name, "_illegal"}, 32'(illegal), 32'(r.ill));
        end
      end
    end
  end

  // Drive one operation, optionally queue its response, and wait (bounded)
  // for the accepting edge. Returns shortly after that edge, in EXEC.
  task automatic applyStimulus(input vec_t v, input bit push);
    bit done;
    done     = 1'b0;
    rs1_data = v.rs1;
    rs2_data = v.rs2;
    imm      = v.imm;
    imm_sext = v.sext;
    use_imm  = v.useImm;
    func     = v.func;
    in_valid = 1'b1;
    if (push) begin
      resp_t r;
      r.name = v.name; r.result = v.expResult; r.zero = v.expZero;
      r.neg = v.expNeg; r.ill = v.expIll;
      expQ.push_back(r);
    end
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      @(posedge clk);
      #2;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_accept_timeout actual=0 required=1", v.name);
    end
  endtask

  // Full op with out_ready high: checks EXEC-cycle ALU drive and the exact
  // cycle out_valid rises.
  task automatic runVector(input vec_t v);
    applyStimulus(v, 1'b1);
    @(negedge clk);
    checkOutput({v.name, "_exec_out_valid"}, 32'(out_valid), 32'd0);
    checkOutput({v.name, "_exec_in_ready"}, 32'(in_ready), 32'd0);
    checkOutput({v.name, "_alu_a"}, alu_a, v.rs1);
    checkOutput({v.name, "_alu_b"}, alu_b, v.expB);
    checkOutput({v.name, "_alu_op"}, 32'(alu_op), 32'(v.expOp));
    @(negedge clk);
    checkOutput({v.name, "_hold_out_valid"}, 32'(out_valid), 32'd1);
    @(posedge clk);
    #2;
  endtask

  initial begin
    vecs[0] = mk("add_wrap", 32'hFFFFFFFF, 32'h1, 16'h0, 1'b0, 1'b0, 3'b000,
                 32'h1, 3'b000, 32'h0, 1'b1, 1'b0, 1'b0);
    vecs[1] = mk("sub_imm", 32'h5, 32'h0, 16'h0007, 1'b1, 1'b1, 3'b001,
                 32'h7, 3'b001, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b0);
    vecs[2] = mk("add_sext", 32'h3, 32'h0, 16'hFFFF, 1'b1, 1'b1, 3'b000,
                 32'hFFFFFFFF, 3'b000, 32'h2, 1'b0, 1'b0, 1'b0);
    vecs[3] = mk("add_zext", 32'h1, 32'h0, 16'hFFFF, 1'b0, 1'b1, 3'b000,
                 32'h0000FFFF, 3'b000, 32'h00010000, 1'b0, 1'b0, 1'b0);
    vecs[4] = mk("sll_mask", 32'h1, 32'h21, 16'h0, 1'b0, 1'b0, 3'b011,
                 32'h1, 3'b011, 32'h2, 1'b0, 1'b0, 1'b0);
    vecs[5] = mk("srl_mask", 32'h80000000, 32'h3F, 16'h0, 1'b0, 1'b0, 3'b100,
                 32'h1F, 3'b100, 32'h1, 1'b0, 1'b0, 1'b0);
    vecs[6] = mk("and", 32'hF0F0F0F0, 32'hFF00FF00, 16'h0, 1'b0, 1'b0, 3'b010,
                 32'hFF00FF00, 3'b010, 32'hF000F000, 1'b0, 1'b1, 1'b0);
    vecs[7] = mk("illegal", 32'h3, 32'h4, 16'h0, 1'b0, 1'b0, 3'b110,
                 32'h4, 3'b000, 32'h0, 1'b1, 1'b0, 1'b1);

    reset     = 1'b1;
    in_valid  = 1'b0;
    rs1_data  = '0;
    rs2_data  = '0;
    imm       = '0;
    imm_sext  = 1'b0;
    use_imm   = 1'b0;
    func      = 3'b000;
    out_ready = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_result", result, 32'h0);
    checkOutput("rst_zero", 32'(zero), 32'd1);
    checkOutput("rst_neg", 32'(neg), 32'd0);
    checkOutput("rst_illegal", 32'(illegal), 32'd0);
    checkOutput("rst_alu_op", 32'(alu_op), 32'd0);
    checkOutput("rst_alu_b", alu_b, 32'h0);
    @(posedge clk);
    #2;

    // Directed vectors with writeback always ready
    foreach (vecs[i]) runVector(vecs[i]);

    // Backpressure: result must stay put and in_ready low while stalled
    out_ready = 1'b0;
    applyStimulus(mk("bp_first", 32'd10, 32'd20, 16'h0, 1'b0, 1'b0, 3'b000,
                     32'd20, 3'b000, 32'd30, 1'b0, 1'b0, 1'b0), 1'b1);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
      checkOutput("bp_result_stable", result, 32'd30);
      checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #2;
    // Release writeback and issue the next op in the same cycle
    out_ready = 1'b1;
    applyStimulus(mk("bp_second", 32'd100, 32'd1, 16'h0, 1'b0, 1'b0, 3'b001,
                     32'd1, 3'b001, 32'd99, 1'b0, 1'b0, 1'b0), 1'b1);
    @(negedge clk);
    checkOutput("b2b_exec_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    checkOutput("b2b_out_valid", 32'(out_valid), 32'd1);
    checkOutput("b2b_result", result, 32'd99);
    @(posedge clk);
    #2;

    // Reset while holding an unretired result
    out_ready = 1'b0;
    applyStimulus(mk("rst_hold", 32'd1, 32'd1, 16'h0, 1'b0, 1'b0, 3'b000,
                     32'd1, 3'b000, 32'd2, 1'b0, 1'b0, 1'b0), 1'b0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("rsthold_pre_out_valid", 32'(out_valid), 32'd1);
    checkOutput("rsthold_pre_result", result, 32'd2);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rsthold_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rsthold_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rsthold_result", result, 32'h0);
    checkOutput("rsthold_zero", 32'(zero), 32'd1);
    checkOutput("rsthold_illegal", 32'(illegal), 32'd0);
    @(posedge clk);
    #2;
    reset     = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rsthold_no_out_valid", 32'(out_valid), 32'd0);

    checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
